// File: rtl/uart_dbus_bridge.sv
// UART-to-dbus initiator bridge: parses R/W command frames from a byte stream,
// issues one dbus transaction per frame and returns the response bytes.
// Optional bus-ack timeout is built when UART_DBUS_BRIDGE_TIMEOUT_EN is defined.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a command byte; unknown commands answered NAK
// S_ADDR  | collecting 4 address bytes, LSB first
// S_WDATA | collecting 4 write-data bytes, LSB first (write only)
// S_BUS   | dbus request held until ack (or timeout when enabled)
// S_RESP  | returning read data (4 bytes), ACK, or timeout NAK
module uart_dbus_bridge #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        dbus_req_o,
  output logic        dbus_w_en_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_w_data_o,
  input  logic [31:0] dbus_r_data_i,
  input  logic        dbus_ack_i,
  output logic        busy_o
);

  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] RSP_NAK = 8'h15;
  localparam logic [7:0] RSP_ACK = 8'h06;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_BUS   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic        r_is_write, w_is_write_nxt;
  logic        r_single, w_single_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic [7:0]  r_tx_data, w_tx_data_nxt;
  logic        r_tx_valid, w_tx_valid_nxt;
  logic        w_tx_fire;
  logic [1:0]  w_cnt_inc;

`ifdef UART_DBUS_BRIDGE_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  assign w_tx_fire = r_tx_valid & tx_ready_i;
  assign w_cnt_inc = r_cnt + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 2'd0;
      r_is_write <= 1'b0;
      r_single   <= 1'b0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_tx_data  <= 8'd0;
      r_tx_valid <= 1'b0;
`ifdef UART_DBUS_BRIDGE_TIMEOUT_EN
      r_to_cnt   <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_is_write <= w_is_write_nxt;
      r_single   <= w_single_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_rdata    <= w_rdata_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
`ifdef UART_DBUS_BRIDGE_TIMEOUT_EN
      r_to_cnt   <= w_to_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_is_write_nxt = r_is_write;
    w_single_nxt   = r_single;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_rdata_nxt    = r_rdata;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
`ifdef UART_DBUS_BRIDGE_TIMEOUT_EN
    w_to_cnt_nxt   = r_to_cnt;
`endif

    // A pending NAK from IDLE may be accepted in any state; RESP overrides below.
    if (w_tx_fire) w_tx_valid_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (rx_valid_i) begin
          if (rx_data_i == CMD_RD || rx_data_i == CMD_WR) begin
            w_is_write_nxt = (rx_data_i == CMD_WR);
            w_cnt_nxt      = 2'd0;
            w_state_nxt    = S_ADDR;
          end else begin
            w_tx_data_nxt  = RSP_NAK;
            w_tx_valid_nxt = 1'b1;
          end
        end
      end

      S_ADDR: begin
        if (rx_valid_i) begin
          w_addr_nxt[{r_cnt, 3'b000} +: 8] = rx_data_i;
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt == 2'd3) begin
            w_cnt_nxt   = 2'd0;
            w_state_nxt = r_is_write ? S_WDATA : S_BUS;
`ifdef UART_DBUS_BRIDGE_TIMEOUT_EN
            w_to_cnt_nxt = '0;
`endif
          end
        end
      end

      S_WDATA: begin
        if (rx_valid_i) begin
          w_wdata_nxt[{r_cnt, 3'b000} +: 8] = rx_data_i;
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt == 2'd3) begin
            w_cnt_nxt   = 2'd0;
            w_state_nxt = S_BUS;
`ifdef UART_DBUS_BRIDGE_TIMEOUT_EN
            w_to_cnt_nxt = '0;
`endif
          end
        end
      end

      S_BUS: begin
        if (dbus_ack_i) begin
          w_rdata_nxt    = r_is_write ? r_rdata : dbus_r_data_i;
          w_tx_data_nxt  = r_is_write ? RSP_ACK : dbus_r_data_i[7:0];
          w_tx_valid_nxt = 1'b1;
          w_single_nxt   = r_is_write;
          w_cnt_nxt      = 2'd0;
          w_state_nxt    = S_RESP;
`ifdef UART_DBUS_BRIDGE_TIMEOUT_EN
        end else if (r_to_cnt == TO_LAST) begin
          w_tx_data_nxt  = RSP_NAK;
          w_tx_valid_nxt = 1'b1;
          w_single_nxt   = 1'b1;
          w_cnt_nxt      = 2'd0;
          w_state_nxt    = S_RESP;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 1'b1;
`endif
        end
      end

      S_RESP: begin
        w_tx_valid_nxt = r_tx_valid;
        if (w_tx_fire) begin
          if (r_single || r_cnt == 2'd3) begin
            w_tx_valid_nxt = 1'b0;
            w_cnt_nxt      = 2'd0;
            w_state_nxt    = S_IDLE;
          end else begin
            w_cnt_nxt     = w_cnt_inc;
            w_tx_data_nxt = r_rdata[{w_cnt_inc, 3'b000} +: 8];
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign tx_data_o     = r_tx_data;
  assign tx_valid_o    = r_tx_valid;
  assign dbus_req_o    = (r_state == S_BUS);
  assign dbus_w_en_o   = r_is_write;
  assign dbus_addr_o   = r_addr;
  assign dbus_w_data_o = r_wdata;
  assign busy_o        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_dbus_bridge.sv
// Bench for uart_dbus_bridge: directed frames plus randomized transactions,
// with expected bus fields and response bytes derived from the frame contents.
module tb_uart_dbus_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        dbus_req;
  logic        dbus_w_en;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_w_data;
  logic [31:0] dbus_r_data = 32'd0;
  logic        dbus_ack = 1'b0;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int req_rises = 0;
  int req_hi = 0;
  logic req_d = 1'b0;

  uart_dbus_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .dbus_req_o(dbus_req), .dbus_w_en_o(dbus_w_en),
    .dbus_addr_o(dbus_addr), .dbus_w_data_o(dbus_w_data),
    .dbus_r_data_i(dbus_r_data), .dbus_ack_i(dbus_ack),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dbus_req) req_hi <= req_hi + 1;
    if (dbus_req && !req_d) req_rises <= req_rises + 1;
    req_d <= dbus_req;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected response for one frame, straight from the protocol rules.
  function automatic void model_resp(input logic [7:0] cmd, input logic [31:0] rd,
                                     output logic [7:0] q[$]);
    q = {};
    if (cmd == 8'h57) q.push_back(8'h06);
    else if (cmd == 8'h52) for (int i = 0; i < 4; i++) q.push_back(rd[8*i +: 8]);
    else q.push_back(8'h15);
  endfunction

  // All tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
    send_byte(cmd);
    if (cmd == 8'h52 || cmd == 8'h57) begin
      for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
      if (cmd == 8'h57) for (int i = 0; i < 4; i++) send_byte(data[8*i +: 8]);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_tx_data"},  32'(tx_data), 32'd0);
    chk({tag, "_req"},      32'(dbus_req), 32'd0);
    chk({tag, "_w_en"},     32'(dbus_w_en), 32'd0);
    chk({tag, "_addr"},     dbus_addr, 32'd0);
    chk({tag, "_wdata"},    dbus_w_data, 32'd0);
    chk({tag, "_busy"},     32'(busy), 32'd0);
  endtask

  // mode 0: always ready, 1: ready one cycle in three, 2: random ready.
  task automatic collect(input logic [7:0] exp_q[$], input int mode, input string tag);
    int   k;
    logic pend;
    logic hold_ok;
    logic [7:0] held;
    logic rdy;
    k = 0; pend = 1'b0; hold_ok = 1'b1; held = 8'd0;
    for (int cyc = 0; cyc < 300 && k < exp_q.size(); cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (pend && (!tx_valid || tx_data !== held)) hold_ok = 1'b0;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 2);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      tx_ready = rdy;
      if (tx_valid) begin
        if (rdy) begin
          chk($sformatf("%s_byte%0d", tag, k), 32'(tx_data), 32'(exp_q[k]));
          k++;
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          held = tx_data;
        end
      end
    end
    chk({tag, "_nbytes"}, 32'(k), 32'(exp_q.size()));
    chk({tag, "_hold"}, 32'(hold_ok), 32'd1);
    @(negedge clk);
    tx_ready = 1'b0;
    chk({tag, "_tx_idle"}, 32'(tx_valid), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                         input int ack_dly, input int mode, input bit inject, input string tag);
    logic [7:0] exp_q[$];
    logic is_cmd;
    logic req_ok;
    int   r0;
    is_cmd = (cmd == 8'h52 || cmd == 8'h57);
    model_resp(cmd, data, exp_q);
    r0 = req_rises;
    send_frame(cmd, addr, data);
    if (is_cmd) begin
      chk({tag, "_req_rise"}, 32'(dbus_req), 32'd1);
      chk({tag, "_w_en"}, 32'(dbus_w_en), 32'(cmd == 8'h57));
      chk({tag, "_addr"}, dbus_addr, addr);
      if (cmd == 8'h57) chk({tag, "_wdata"}, dbus_w_data, data);
      req_ok = 1'b1;
      for (int i = 0; i < ack_dly; i++) begin
        rx_valid = inject && (i == 0);
        rx_data  = 8'h57;
        dbus_r_data = $urandom;
        @(negedge clk);
        rx_valid = 1'b0;
        if (!dbus_req) req_ok = 1'b0;
      end
      chk({tag, "_req_hold"}, 32'(req_ok), 32'd1);
      dbus_ack = 1'b1;
      dbus_r_data = data;
      @(negedge clk);
      dbus_ack = 1'b0;
      dbus_r_data = ~data;
      chk({tag, "_req_drop"}, 32'(dbus_req), 32'd0);
      chk({tag, "_tx_first"}, 32'(tx_valid), 32'd1);
    end else begin
      chk({tag, "_nak_valid"}, 32'(tx_valid), 32'd1);
      chk({tag, "_nak_idle"}, 32'(busy), 32'd0);
    end
    collect(exp_q, mode, tag);
    repeat (3) @(negedge clk);
    chk({tag, "_req_count"}, 32'(req_rises - r0), is_cmd ? 32'd1 : 32'd0);
    chk({tag, "_quiet"}, 32'(dbus_req), 32'd0);
  endtask

  initial begin
    logic [7:0] cmd;
    int hi0;
    int r0;

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run_txn(8'h57, 32'h2000_0010, 32'hDEAD_BEEF, 2, 0, 1'b0, "write");
    run_txn(8'h52, 32'h2000_0004, 32'h1234_5678, 1, 1, 1'b0, "read");
    run_txn(8'h41, 32'h0, 32'h0, 0, 0, 1'b0, "unknown");
    run_txn(8'h52, 32'h2000_0008, 32'hCAFE_F00D, 0, 2, 1'b0, "read_after_nak");

    send_byte(8'h52); send_byte(8'h04); send_byte(8'h00);
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_midframe");
    rst = 1'b0;
    run_txn(8'h52, 32'h2000_0004, 32'h0BAD_CAFE, 1, 0, 1'b0, "read_post_rst");

    r0 = req_rises;
    send_frame(8'h52, 32'h2000_000C, 32'h0);
    chk("rst_bus_req_pre", 32'(dbus_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("rst_bus");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_bus_no_rereq", 32'(req_rises - r0), 32'd1);
    run_txn(8'h52, 32'h2000_0014, 32'h5566_7788, 2, 1, 1'b0, "read_post_bus_rst");

    run_txn(8'h52, 32'h2000_0000, 32'hA1B2_C3D4, 3, 0, 1'b1, "inject");
    run_txn(8'h57, 32'h1000_0000, 32'h0102_0304, 0, 0, 1'b0, "write_minlat");

`ifdef UART_DBUS_BRIDGE_TIMEOUT_EN
    begin
      logic [7:0] nak_q[$];
      nak_q = {8'h15};
      send_frame(8'h52, 32'h3000_0000, 32'h0);
      hi0 = req_hi;
      for (int i = 0; i < 40 && !tx_valid; i++) @(negedge clk);
      chk("timeout_req_cycles", 32'(req_hi - hi0), 32'd16);
      chk("timeout_valid", 32'(tx_valid), 32'd1);
      chk("timeout_req_low", 32'(dbus_req), 32'd0);
      collect(nak_q, 0, "timeout");
      run_txn(8'h52, 32'h3000_0004, 32'h9988_7766, 15, 0, 1'b0, "ack_at_expiry");
    end
`else
    hi0 = 0;
`endif

    for (int n = 0; n < 12; n++) begin
      case ($urandom_range(0, 4))
        0, 1:    cmd = 8'h52;
        2, 3:    cmd = 8'h57;
        default: begin
          cmd = 8'($urandom);
          if (cmd == 8'h52 || cmd == 8'h57) cmd = 8'hFF;
        end
      endcase
      run_txn(cmd, $urandom, $urandom, int'($urandom_range(0, 4)), 2,
              1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed running expected done");
    $fatal(1, "watchdog");
  end

endmodule
